mem_access_seq: RTL and testbench

Load/store access sequencer between the EX/MEM pipeline register and the 64-bit data memory. Accepts one RV64 load or store per request and converts it into one or two dword-aligned memory accesses with byte enables. A request that straddles a dword boundary is split into a low and a high access. Load data is merged, shifted and sign/zero-extended before it is returned to the pipeline, so the data memory only ever sees aligned dword traffic.

---
 rtl/mem_access_seq.sv | 153 +++++++++++++++
 tb/tb_mem_access_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// Load/store access sequencer: splits an RV64 load/store into one or two
// dword-aligned memory accesses and merges/extends load data for the pipeline.
module mem_access_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_ctrl,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] dmem_addr,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic [7:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse in DONE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic             r_write;
  logic [2:0]       r_ctrl;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic [3:0]       w_nbytes;
  logic             w_span;
  logic [15:0]      w_mask;
  logic [5:0]       w_shamt;
  logic [WIDTH-1:0] w_wtrunc;
  logic [127:0]     w_sdata;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_ext;
  logic             w_last_acc;
  logic [WIDTH-1:0] w_base;

  assign w_nbytes   = 4'd1 << r_ctrl[1:0];
  assign w_span     = ({1'b0, r_addr[2:0]} + w_nbytes) > 4'd8;
  assign w_mask     = ((16'd1 << w_nbytes) - 16'd1) << r_addr[2:0];
  assign w_shamt    = {r_addr[2:0], 3'b000};
  assign w_sdata    = {64'd0, w_wtrunc} << w_shamt;
  assign w_base     = {r_addr[WIDTH-1:3], 3'b000};
  assign w_last_acc = (r_state == S_ACC1) || ((r_state == S_ACC0) && !w_span);

  always_comb begin
    w_wtrunc = '0;
    case (r_ctrl[1:0])
      2'd0:    w_wtrunc = {56'd0, r_wdata[7:0]};
      2'd1:    w_wtrunc = {48'd0, r_wdata[15:0]};
      2'd2:    w_wtrunc = {32'd0, r_wdata[31:0]};
      default: w_wtrunc = r_wdata;
    endcase
  end

  // In ACC1 the low dword was captured in ACC0; otherwise hi reads as zero.
  assign w_hi  = (r_state == S_ACC1) ? dmem_rdata : '0;
  assign w_lo  = (r_state == S_ACC1) ? r_lo : dmem_rdata;
  assign w_raw = 64'({w_hi, w_lo} >> w_shamt);

  always_comb begin
    w_ext = '0;
    case (r_ctrl)
      3'b000:  w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
      3'b010:  w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
      3'b011:  w_ext = w_raw;
      3'b100:  w_ext = {56'd0, w_raw[7:0]};
      3'b101:  w_ext = {48'd0, w_raw[15:0]};
      3'b110:  w_ext = {32'd0, w_raw[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_ctrl  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_ctrl  <= req_ctrl;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= (req_ctrl == 3'b111);
            r_state <= (req_ctrl == 3'b111) ? S_DONE : S_ACC0;
          end
        end
        S_ACC0: begin
          if (!r_write) r_lo <= dmem_rdata;
          r_state <= w_span ? S_ACC1 : S_DONE;
        end
        S_ACC1:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      if (!r_write && w_last_acc) r_rdata <= w_ext;
    end
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (r_state == S_ACC0) begin
      dmem_addr  = w_base;
      dmem_re    = !r_write;
      dmem_we    = r_write;
      dmem_be    = w_mask[7:0];
      dmem_wdata = r_write ? w_sdata[63:0] : '0;
    end else if (r_state == S_ACC1) begin
      dmem_addr  = w_base + 64'd8;
      dmem_re    = !r_write;
      dmem_we    = r_write;
      dmem_be    = w_mask[15:8];
      dmem_wdata = r_write ? w_sdata[127:64] : '0;
    end
  end

  assign req_ready  = rst_n && (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_err   = (r_state == S_DONE) && r_err;
  assign resp_rdata = (r_state == S_DONE) ? r_rdata : '0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: byte-addressed reference memory model, directed
// cases from the access rules plus randomized loads/stores.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_ctrl;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] dmem_addr;
  logic        dmem_re;
  logic        dmem_we;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  // Bench memory: 32 dwords aliased on address bits [7:3]
  logic [63:0] mem [0:31];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [63:0] pre_val;
  // Reference model: flat byte array indexed by address bits [7:0]
  logic [7:0]  ref_bytes [0:255];

  logic [63:0] acc_addr [0:3];
  logic [7:0]  acc_be   [0:3];
  logic [63:0] acc_wd   [0:3];
  logic [1:0]  acc_kind [0:3];

  always #5 clk = ~clk;

  mem_access_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dbg_state(dbg_state)
  );

  assign dmem_rdata = mem[dmem_addr[7:3]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (dmem_we)
      for (int k = 0; k < 8; k++)
        if (dmem_be[k]) mem[dmem_addr[7:3]][8*k +: 8] <= dmem_wdata[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] c);
    return 1 << c[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] c, input logic [63:0] a);
    int n;
    logic [63:0] v;
    logic [7:0] ba;
    n = nbytes(c);
    v = '0;
    for (int i = 0; i < n; i++) begin
      ba = a[7:0] + 8'(i);
      v[8*i +: 8] = ref_bytes[ba];
    end
    if (!c[2] && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_dword(input logic [4:0] idx, input logic [63:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    for (int k = 0; k < 8; k++) ref_bytes[{idx, 3'(k)}] = val[8*k +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] c, input logic [63:0] a,
                        input logic [63:0] wd, input bit hold, output logic [63:0] got);
    int n, nexp, nacc, lat, wait_cyc;
    bit illegal, timeout, busy_ready;
    logic [63:0] exp, base, rel;
    logic [7:0]  ebe;
    logic [63:0] ewd;
    illegal = (c == 3'b111);
    n = nbytes(c);
    nexp = illegal ? 0 : ((((a + 64'(n) - 64'd1) >> 3) != (a >> 3)) ? 2 : 1);
    exp_q.push_back((illegal || wr) ? 64'd0 : model_load(c, a));
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_ctrl = c; req_addr = a; req_wdata = wd;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    nacc = 0; lat = 0; busy_ready = 1'b0; timeout = 1'b1; got = '0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (req_ready) busy_ready = 1'b1;
      if (dmem_re || dmem_we) begin
        if (nacc < 4) begin
          acc_addr[nacc] = dmem_addr; acc_be[nacc] = dmem_be;
          acc_wd[nacc] = dmem_wdata;  acc_kind[nacc] = {dmem_re, dmem_we};
        end
        nacc++;
      end
      if (resp_valid) begin
        lat = t; timeout = 1'b0;
        got = resp_rdata;
        chk("resp_err", 64'(resp_err), 64'(illegal));
        break;
      end
    end
    chk("resp_timeout", 64'(timeout), 64'd0);
    chk("latency", 64'(lat), illegal ? 64'd1 : 64'(nexp + 1));
    chk("busy_ready_low", 64'(busy_ready), 64'd0);
    chk("access_count", 64'(nacc), 64'(nexp));
    exp = exp_q.pop_front();
    chk("resp_rdata", got, exp);
    for (int j = 0; j < nexp && j < nacc; j++) begin
      base = {a[63:3], 3'b000} + 64'(8*j);
      chk("acc_addr", acc_addr[j], base);
      chk("acc_kind", 64'(acc_kind[j]), wr ? 64'd1 : 64'd2);
      if (wr) begin
        ebe = '0; ewd = '0;
        for (int k = 0; k < 8; k++) begin
          rel = base + 64'(k) - a;
          if (rel < 64'(n)) begin
            ebe[k] = 1'b1;
            ewd[8*k +: 8] = wd[8*rel[2:0] +: 8];
          end
        end
        chk("acc_be", 64'(acc_be[j]), 64'(ebe));
        chk("acc_wdata", acc_wd[j], ewd);
      end
    end
    if (wr && !illegal)
      for (int i = 0; i < n; i++) ref_bytes[a[7:0] + 8'(i)] = wd[8*i +: 8];
  endtask

  logic [63:0] got;
  logic [63:0] expd;
  bit          seen;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_ctrl = '0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 32; i++) set_dword(5'(i), {$urandom, $urandom});
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_strobes", {61'd0, dmem_re, dmem_we, resp_valid}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_outs", {55'd0, dmem_be, resp_err}, 64'd0);

    set_dword(5'd2, 64'h1122334455667788);
    do_req(1'b0, 3'b011, 64'h10, 64'd0, 1'b0, got);
    chk("ld_aligned", got, 64'h1122334455667788);

    set_dword(5'd1, 64'h8877665544332211);
    do_req(1'b0, 3'b000, 64'h0F, 64'd0, 1'b0, got);
    chk("lb_0f", got, 64'hFFFF_FFFF_FFFF_FF88);
    do_req(1'b0, 3'b100, 64'h0F, 64'd0, 1'b0, got);
    chk("lbu_0f", got, 64'h88);
    do_req(1'b0, 3'b001, 64'h0A, 64'd0, 1'b0, got);
    chk("lh_0a", got, 64'h4433);

    set_dword(5'd2, 64'hFFEEDDCCBBAA9988);
    do_req(1'b0, 3'b010, 64'h0E, 64'd0, 1'b0, got);
    chk("lw_span", got, 64'hFFFF_FFFF_9988_8877);
    do_req(1'b0, 3'b110, 64'h0E, 64'd0, 1'b0, got);
    chk("lwu_span", got, 64'h9988_8877);

    do_req(1'b1, 3'b001, 64'h0F, 64'hABCD, 1'b0, got);
    chk("sh_acc0_be", 64'(acc_be[0]), 64'h80);
    chk("sh_acc0_byte", 64'(acc_wd[0][63:56]), 64'hCD);
    chk("sh_acc1_be", 64'(acc_be[1]), 64'h01);
    chk("sh_acc1_byte", 64'(acc_wd[1][7:0]), 64'hAB);
    chk("sh_rdata", got, 64'd0);

    // Second request held valid throughout a spanning load
    do_req(1'b0, 3'b010, 64'h0E, 64'd0, 1'b1, got);
    do_req(1'b0, 3'b010, 64'h0E, 64'd0, 1'b0, got);
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (resp_valid || dmem_re || dmem_we) seen = 1'b1;
    end
    chk("held_accepted_once", 64'(seen), 64'd0);

    do_req(1'b0, 3'b111, 64'h20, 64'd0, 1'b0, got);
    do_req(1'b1, 3'b111, 64'h23, 64'hDEAD, 1'b0, got);

    do_req(1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, got);
    chk("wrap_acc1_addr", acc_addr[1], 64'd0);

    // Reset during ACC0 of a spanning SD: nothing may be written
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_ctrl = 3'b011;
    req_addr = 64'h0C; req_wdata = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_acc0_we", 64'(dmem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {62'd0, dmem_re, dmem_we}, 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    seen = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if (resp_valid || dmem_we || dmem_re) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (resp_valid || dmem_we || dmem_re) seen = 1'b1;
    end
    chk("rst_mid_no_activity", 64'(seen), 64'd0);
    chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
    chk("rst_mid_be", 64'(dmem_be), 64'd0);

    for (int i = 0; i < 200; i++) begin
      logic [63:0] ra;
      ra = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ra = {56'hFFFF_FFFF_FFFF_FF, ra[7:0]};
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
             {$urandom, $urandom}, 1'b0, got);
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 8; k++) expd[8*k +: 8] = ref_bytes[{5'(i), 3'(k)}];
      chk("mem_final", mem[i], expd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
